fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- Sequencer directly upstream of the floating-point arithmetic units (FADD, FSUB, FMUL, FDIV) in the MIX core.
- On a floating opcode (C=1..4) it:
  - selects the unit from the field code F;
  - presents rA and then the memory operand V on a shared operand bus, in the order the units sample them;
  - waits for the unit's stop;
  - writes the result back to rA and raises the overflow toggle.
- Also rejects illegal F codes and enforces a watchdog timeout.

Parameters:
- TIMEOUT, 63: maximum WAIT cycles before abort. Range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from the CPU sequencer; ignored while busy
- fcode  in  3  unit select: 1=FADD, 2=FSUB, 3=FMUL, 4=FDIV; others illegal
- rega  in  31  current rA (sign bit 30, exponent 29:24, fraction 23:0); sampled when start is accepted
- mem  in  31  operand V; sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted through the WRITE cycle
- done  out  1  one-cycle completion pulse
- a_we  out  1  one-cycle rA write enable, coincident with done
- a_out  out  31  rA write data, valid while a_we=1
- ov_set  out  1  one-cycle pulse, coincident with done; sets the CPU overflow toggle
- illegal  out  1  one-cycle pulse, coincident with done, for an illegal fcode
- u_start  out  4  one-hot unit start; bit0=FADD … bit3=FDIV
- opnd  out  31  shared operand bus to all units
- u_stop  in  4  per-unit stop; result valid in the same cycle
- u_out  in  124  four 31-bit results; unit k occupies bits 31k+30:31k
- u_ovf  in  4  per-unit overflow, valid with stop

Behaviour:
- Reset values: FSM=IDLE; busy, done, a_we, ov_set, illegal, u_start all 0; opnd=0; a_out=0.
- Reset asserted in any state returns the FSM to IDLE on the next edge. No done, write or start is produced afterwards.
- FSM states: IDLE, ISSUE, OPB, WAIT, WRITE.
- IDLE
  - start=1 and fcode in 1..4: latch rega to A, mem to V, one-hot select to SEL; go to ISSUE.
  - start=1 and fcode illegal: go to WRITE with illegal flag set; no unit is started.
  - opnd=0.
- ISSUE (1 cycle)
  - u_start=SEL; opnd=A (first operand / dividend).
  - Always go to OPB.
- OPB (1 cycle)
  - u_start=0; opnd=V (second operand / divisor). Units sample it in the first cycle of their run.
  - Selected stop=1: latch result and overflow, go to WRITE. Otherwise go to WAIT.
- WAIT
  - opnd holds V.
  - Watchdog counter clears on entry and increments each WAIT cycle.
  - Selected stop=1: latch result R=u_out slice and OVF=u_ovf bit; go to WRITE.
  - Else counter == TIMEOUT-1: set timeout flag; go to WRITE.
  - Stops from non-selected units are ignored.
- WRITE (1 cycle)
  - done=1.
  - Normal completion: a_we=1, a_out=R, ov_set=OVF.
  - Timeout: a_we=0, ov_set=1.
  - Illegal fcode: a_we=0, ov_set=0, illegal=1.
  - Always return to IDLE.
- start is accepted only in IDLE. start asserted in the WRITE cycle is ignored; the CPU re-issues after done.
- Latency, counted from the start cycle (cycle 0):
  - ISSUE in cycle 1, OPB in cycle 2.
  - A unit stopping in cycle n (n≥2) gives done in cycle n+1.
  - FDIV (stop at its count 9, i.e. cycle 11) gives done in cycle 12.
  - Illegal fcode gives done in cycle 1.
- busy is high in ISSUE, OPB, WAIT and WRITE.
- The result is passed through unmodified; zero/sign handling is owned by the units.

Test Plan:
1. Stub FDIV stops 9 cycles after its run begins, out=31'h2A00_0001, ovf=0. start with fcode=4, rega=31'h0104_0000, mem=31'h0108_0000 -> u_start=4'b1000 in cycle 1; opnd=31'h0104_0000 in cycle 1 and 31'h0108_0000 in cycle 2; done and a_we in cycle 12 with a_out=31'h2A00_0001, ov_set=0.
2. FDIV stub returns ovf=1 (divide by zero, mem=0) -> cycle 12: a_we=1, ov_set=1.
3. Stub FADD stops in cycle 2 (OPB) with out=31'h4000_0000 -> done and a_we in cycle 3, a_out=31'h4000_0000.
4. fcode=0 and fcode=6 -> done and illegal in cycle 1; a_we=0, ov_set=0; u_start stays 0.
5. TIMEOUT=8, FMUL stub never stops -> done in cycle 11 (WAIT cycles 3..10); ov_set=1, a_we=0; FSM back in IDLE in cycle 12.
6. Reset asserted in WAIT; FDIV stop arrives 2 cycles later -> no done or a_we; busy=0 after the reset edge. A following FSUB (fcode=2) request completes normally. Also verify that start pulses while busy, and stops from non-selected units, are ignored.

Source files
------------

// File: rtl/fpu_issue.sv
// Issue sequencer for the MIX floating-point units: selects FADD/FSUB/FMUL/FDIV,
// drives rA then V on the shared operand bus, waits for stop, writes the result back.
module fpu_issue #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   fcode,
    input  logic [30:0]  rega,
    input  logic [30:0]  mem,
    output logic         busy,
    output logic         done,
    output logic         a_we,
    output logic [30:0]  a_out,
    output logic         ov_set,
    output logic         illegal,
    output logic [3:0]   u_start,
    output logic [30:0]  opnd,
    input  logic [3:0]   u_stop,
    input  logic [123:0] u_out,
    input  logic [3:0]   u_ovf
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StOpb,
        StWait,
        StWrite
    } state_e;

    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    state_e      state;
    logic [30:0] v_reg;
    logic [1:0]  idx;
    logic [7:0]  wd_cnt;

    logic        legal;
    logic [3:0]  onehot;
    logic        sel_stop;
    logic        sel_ovf;
    logic [30:0] sel_res;

    always_comb begin
        legal    = (fcode >= 3'd1) && (fcode <= 3'd4);
        onehot   = 4'b0001 << (fcode - 3'd1);
        sel_stop = u_stop[idx];
        sel_ovf  = u_ovf[idx];
        unique case (idx)
            2'd0: sel_res = u_out[30:0];
            2'd1: sel_res = u_out[61:31];
            2'd2: sel_res = u_out[92:62];
            2'd3: sel_res = u_out[123:93];
        endcase
    end

    // All outputs are registered: each is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_we    <= 1'b0;
            a_out   <= '0;
            ov_set  <= 1'b0;
            illegal <= 1'b0;
            u_start <= '0;
            opnd    <= '0;
            v_reg   <= '0;
            idx     <= '0;
            wd_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            a_we    <= 1'b0;
            ov_set  <= 1'b0;
            illegal <= 1'b0;
            u_start <= '0;
            case (state)
                StIdle: begin
                    if (start && legal) begin
                        v_reg   <= mem;
                        idx     <= 2'(fcode - 3'd1);
                        u_start <= onehot;
                        opnd    <= rega;
                        busy    <= 1'b1;
                        state   <= StIssue;
                    end else if (start) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StWrite;
                    end
                end
                StIssue: begin
                    opnd  <= v_reg;
                    state <= StOpb;
                end
                StOpb, StWait: begin
                    // A stop in the final watchdog cycle still counts as a normal completion.
                    if (sel_stop) begin
                        done   <= 1'b1;
                        a_we   <= 1'b1;
                        a_out  <= sel_res;
                        ov_set <= sel_ovf;
                        state  <= StWrite;
                    end else if (state == StOpb) begin
                        wd_cnt <= '0;
                        state  <= StWait;
                    end else if (wd_cnt == WdLast) begin
                        done   <= 1'b1;
                        ov_set <= 1'b1;
                        state  <= StWrite;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                StWrite: begin
                    busy  <= 1'b0;
                    opnd  <= '0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    opnd  <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: directed table, reset-in-WAIT sequence and randomized
// operations against a closed-form latency/result model.
module tb_fpu_issue;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_a, start_b;
    logic [2:0]   fcode;
    logic [30:0]  rega, mem;
    logic [3:0]   u_stop, u_ovf;
    logic [123:0] u_out;

    logic         busy_a, done_a, a_we_a, ov_set_a, illegal_a;
    logic [30:0]  a_out_a, opnd_a;
    logic [3:0]   u_start_a;
    logic         busy_b, done_b, a_we_b, ov_set_b, illegal_b;
    logic [30:0]  a_out_b, opnd_b;
    logic [3:0]   u_start_b;

    logic         use_t;
    logic         busy, done, a_we, ov_set, illegal;
    logic [30:0]  a_out, opnd;
    logic [3:0]   u_start;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_issue #(.TIMEOUT(63)) dut (
        .clk(clk), .reset(reset), .start(start_a), .fcode(fcode), .rega(rega), .mem(mem),
        .busy(busy_a), .done(done_a), .a_we(a_we_a), .a_out(a_out_a), .ov_set(ov_set_a),
        .illegal(illegal_a), .u_start(u_start_a), .opnd(opnd_a),
        .u_stop(u_stop), .u_out(u_out), .u_ovf(u_ovf)
    );

    fpu_issue #(.TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .start(start_b), .fcode(fcode), .rega(rega), .mem(mem),
        .busy(busy_b), .done(done_b), .a_we(a_we_b), .a_out(a_out_b), .ov_set(ov_set_b),
        .illegal(illegal_b), .u_start(u_start_b), .opnd(opnd_b),
        .u_stop(u_stop), .u_out(u_out), .u_ovf(u_ovf)
    );

    always_comb begin
        busy    = use_t ? busy_b    : busy_a;
        done    = use_t ? done_b    : done_a;
        a_we    = use_t ? a_we_b    : a_we_a;
        a_out   = use_t ? a_out_b   : a_out_a;
        ov_set  = use_t ? ov_set_b  : ov_set_a;
        illegal = use_t ? illegal_b : illegal_a;
        u_start = use_t ? u_start_b : u_start_a;
        opnd    = use_t ? opnd_b    : opnd_a;
    end

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One operation from its start cycle (0) to the first IDLE cycle after done.
    task automatic do_op(input bit t, input logic [2:0] fc, input logic [30:0] ra,
                         input logic [30:0] mv, input int stop_cyc, input logic [30:0] res,
                         input logic ovf, input bit noise);
        int         tmo, done_cyc, k;
        bit         legal;
        logic [3:0] oh;
        logic       ewe, eov;
        tmo   = t ? 8 : 63;
        legal = (fc >= 3'd1) && (fc <= 3'd4);
        k     = legal ? int'(fc) - 1 : 0;
        oh    = legal ? 4'(1 << k) : 4'b0;
        if (!legal) begin
            done_cyc = 1; ewe = 1'b0; eov = 1'b0;
        end else if (stop_cyc >= 2 && stop_cyc <= 2 + tmo) begin
            done_cyc = stop_cyc + 1; ewe = 1'b1; eov = ovf;
        end else begin
            done_cyc = 3 + tmo; ewe = 1'b0; eov = 1'b1;
        end
        use_t = t;
        @(posedge clk); #1;
        fcode = fc; rega = ra; mem = mv; u_stop = '0;
        start_a = !t; start_b = t;
        @(negedge clk);
        chk("busy_idle", 0, 32'(busy), 32'(0));
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            rega = 31'($urandom); mem = 31'($urandom);
            u_stop = '0; u_ovf = 4'($urandom);
            u_out = {$urandom, $urandom, $urandom, $urandom};
            if (noise) begin
                u_stop = 4'($urandom) & ~oh;
                if (c <= done_cyc && $urandom_range(0, 2) == 0) begin
                    fcode = 3'($urandom);
                    if (t) start_b = 1'b1; else start_a = 1'b1;
                end
            end
            if (legal && c == stop_cyc) begin
                u_stop[k] = 1'b1; u_out[31*k +: 31] = res; u_ovf[k] = ovf;
            end
            @(negedge clk);
            chk("busy", c, 32'(busy), 32'(c <= done_cyc));
            chk("done", c, 32'(done), 32'(c == done_cyc));
            chk("u_start", c, 32'(u_start), 32'(c == 1 ? oh : 4'b0));
            if (c == done_cyc) begin
                chk("a_we", c, 32'(a_we), 32'(ewe));
                chk("ov_set", c, 32'(ov_set), 32'(eov));
                chk("illegal", c, 32'(illegal), 32'(!legal));
                if (ewe) chk("a_out", c, 32'(a_out), 32'(res));
            end else begin
                chk("a_we_idle", c, 32'(a_we), 32'(0));
                chk("illegal_idle", c, 32'(illegal), 32'(0));
            end
            if (legal && c < done_cyc) chk("opnd", c, 32'(opnd), 32'(c == 1 ? ra : mv));
            if (c == done_cyc + 1) chk("opnd_idle", c, 32'(opnd), 32'(0));
        end
    endtask

    typedef struct {
        bit          t;
        logic [2:0]  fc;
        logic [30:0] ra;
        logic [30:0] mv;
        int          stop;
        logic [30:0] res;
        logic        ovf;
        bit          noise;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 3'd4, 31'h0104_0000, 31'h0108_0000, 11, 31'h2A00_0001, 1'b0, 0};
        tbl[1] = '{0, 3'd4, 31'h0104_0000, 31'h0000_0000, 11, 31'h3FFF_FFFF, 1'b1, 0};
        tbl[2] = '{0, 3'd1, 31'h0123_4567, 31'h0765_4321, 2,  31'h4000_0000, 1'b0, 0};
        tbl[3] = '{0, 3'd0, 31'h1111_1111, 31'h2222_2222, -1, 31'h0,         1'b0, 0};
        tbl[4] = '{0, 3'd6, 31'h1111_1111, 31'h2222_2222, -1, 31'h0,         1'b0, 0};
        tbl[5] = '{1, 3'd3, 31'h0555_0000, 31'h0666_0000, -1, 31'h0,         1'b0, 0};
        tbl[6] = '{1, 3'd2, 31'h0A00_0000, 31'h0B00_0000, 10, 31'h1357_9BDF, 1'b1, 1};
        tbl[7] = '{1, 3'd1, 31'h0C00_0000, 31'h0D00_0000, 11, 31'h7654_3210, 1'b0, 1};
        tbl[8] = '{0, 3'd7, 31'h0E00_0000, 31'h0F00_0000, -1, 31'h0,         1'b0, 1};

        use_t = 1'b0; reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fcode = '0; rega = '0; mem = '0; u_stop = '0; u_ovf = '0; u_out = '0;
        repeat (3) @(posedge clk);
        #1 rega = 31'h7FFF_FFFF; mem = 31'h7FFF_FFFF; fcode = 3'd1; start_a = 1'b1;
        @(negedge clk);
        chk("rst_busy", 0, 32'(busy_a), 32'(0));
        chk("rst_done", 0, 32'(done_a), 32'(0));
        chk("rst_a_we", 0, 32'(a_we_a), 32'(0));
        chk("rst_ov_set", 0, 32'(ov_set_a), 32'(0));
        chk("rst_illegal", 0, 32'(illegal_a), 32'(0));
        chk("rst_u_start", 0, 32'(u_start_a), 32'(0));
        chk("rst_opnd", 0, 32'(opnd_a), 32'(0));
        chk("rst_a_out", 0, 32'(a_out_a), 32'(0));
        @(posedge clk); #1 reset = 1'b0; start_a = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(tbl[i].t, tbl[i].fc, tbl[i].ra, tbl[i].mv, tbl[i].stop, tbl[i].res,
                  tbl[i].ovf, tbl[i].noise);

        // Reset while FDIV is in WAIT; its stop arrives two cycles after the reset edge.
        use_t = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            start_a = (c == 0); fcode = 3'd4;
            rega = 31'h0104_0000; mem = 31'h0108_0000;
            reset  = (c == 5);
            u_stop = (c == 7) ? 4'b1000 : 4'b0000;
            u_out  = {31'h2A00_0001, 93'h0}; u_ovf = 4'b0;
            @(negedge clk);
            if (c >= 1) begin
                chk("rstw_busy", c, 32'(busy_a), 32'(c <= 5));
                chk("rstw_done", c, 32'(done_a), 32'(0));
                chk("rstw_a_we", c, 32'(a_we_a), 32'(0));
            end
            if (c >= 6) chk("rstw_u_start", c, 32'(u_start_a), 32'(0));
        end
        do_op(0, 3'd2, 31'h0246_8ACE, 31'h0135_7924, 4, 31'h0FED_CBA9, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            bit          t;
            logic [2:0]  fc;
            int          sc;
            t  = 1'($urandom_range(0, 1));
            fc = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4))
                                            : 3'($urandom_range(5, 8));
            sc = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, t ? 12 : 20));
            do_op(t, fc, 31'($urandom), 31'($urandom), sc, 31'($urandom),
                  1'($urandom), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
